tbu_ctrl: RTL
=============

# tbu_ctrl

Sequencing controller for the survivor-path memory and the `tbu` traceback unit of the Viterbi decoder. It accepts 8-bit ACS decision words and writes them into three rotating survivor-memory banks. Each time a block completes, it runs one traceback pass over the two older banks: a trace phase first, then a decode phase. It drives memory addresses plus `tbu` `enable`/`selection`, and applies back-pressure to the ACS stage when a bank rotation would collide with a pass in progress. It sits in the top level between the ACS array, the survivor RAM and `tbu`.

## Interface
- `DEPTH`, 8: decision words per bank. Power of two, ≥4.
- `AW`, `$clog2(DEPTH)`: address width.

- `clk` in 1: the single clock. All logic is on the rising edge.
- `rst` in 1: reset. Synchronous and active-high.
- `dec_valid` in 1: ACS decision word is valid.
- `dec_ready` out 1: controller accepts the word. A transfer occurs when `dec_valid && dec_ready`.
- `mem_we` out 1: survivor RAM write enable. Equals the transfer condition.
- `mem_wr_bank` out 2: bank being written (0..2).
- `mem_wr_addr` out AW: write address.
- `mem_rd_en` out 1: RAM read strobe. RAM read latency is 1 cycle. Read data drives both `d_in_0` and `d_in_1` of `tbu`.
- `mem_rd_bank` out 2: bank being read.
- `mem_rd_addr` out AW: read address.
- `tbu_enable` out 1: to `tbu.enable`. Aligned with returning read data.
- `tbu_selection` out 1: to `tbu.selection`. 0 = trace, 1 = decode. Aligned with returning read data.
- `pass_done` out 1: one-cycle pulse, in the cycle after the last aligned decode cycle.

## Operation
- **Write side**
  - `wr_bank` (mod-3) and `wr_addr` (0..DEPTH-1) counters advance on each transfer.
  - The transfer at `wr_addr==DEPTH-1` is `blk_done`: `wr_addr`→0 and `wr_bank`→`(wr_bank+1)%3`, with wrap 2→0.
- **Fill counter:** `blk_cnt` saturates at 2 and increments on `blk_done`.
- **`dec_ready`:** `= !rst && !(wr_addr==DEPTH-1 && state∈{TRACE,DECODE})`. The last word of a block is held off while a pass reads the banks that the rotation would reuse.
- **FSM states:** IDLE, TRACE, DECODE, WAIT.
  - IDLE/WAIT → TRACE on `blk_done` when `blk_cnt` (after increment) ≥2. On that transition, latch `tr_bank` = the bank just completed and `dc_bank = (tr_bank+2)%3`.
  - TRACE: `mem_rd_bank=tr_bank`, `mem_rd_addr` DEPTH-1 down to 0, one per cycle, `mem_rd_en=1`. At addr 0 → DECODE.
  - DECODE: same sweep on `dc_bank`. At addr 0 → WAIT.
  - WAIT: no reads. Stays until the next `blk_done`.
- **`tbu` drive:** `tbu_enable`/`tbu_selection` are registered copies of (state∈{TRACE,DECODE}, state==DECODE). Both are 0 otherwise.
  - The 1→0 edge of `tbu_enable` or `tbu_selection` resets the `tbu` state to 0 before the next pass.
- **Throughput:** a pass takes 2·DEPTH cycles per DEPTH words, so the sustained input rate is 1/2 word per cycle. Back-pressure enforces this.

## Timing
- **Reset values** (cycle after `rst` is sampled high): all outputs 0, state IDLE, counters 0, `blk_cnt`=0. `dec_ready` is 1 from the first cycle with `rst` low.
- **Reset mid-pass:** the pass is aborted immediately. `tbu_enable` is 0 the next cycle, and buffered banks are discarded: 2·DEPTH fresh words are needed before the next pass.
- **Pass start:** first TRACE read is 1 cycle after `blk_done`. `tbu_enable` rises 2 cycles after `blk_done`.
- **Read alignment:** each `tbu_*` value lags the read issue by exactly 1 cycle. `tbu` output bits then follow after `tbu`'s own register, in reverse order.
- **`pass_done`:** pulses in the cycle `tbu_enable` falls.
- **Simultaneous events:** the last DECODE cycle still counts as busy, so the held word is accepted in WAIT at the earliest (one-cycle conservative). `blk_done` in WAIT → TRACE next cycle.
- **`dec_valid` low:** counters hold; the FSM is unaffected.

## Structure
- `viterbi_pkg` holds:
  - `NUM_BANKS=3`
  - `typedef logic [1:0] bank_t`
  - the state enum `tbu_ctrl_state_e` (IDLE, TRACE, DECODE, WAIT)
  - `function bank_t bank_inc(bank_t)` for mod-3 wrap
- No sub-module: counters and FSM are inline. `tbu` and the RAM are instantiated alongside in the top level.

## Test plan
- **Reset:** hold `rst` 3 cycles with `dec_valid`=1 → no `mem_we`, all outputs 0; `dec_ready`=1 the first cycle after release.
- **Fill (DEPTH=8):** 16 words back-to-back from cycle 0 → `wr_bank` 0 then 1.
  - Cycles 16–23: `mem_rd_bank`=1, addr 7..0.
  - Cycles 24–31: `mem_rd_bank`=0, addr 7..0.
  - `tbu_selection` is 0 for cycles 17–24 and 1 for 25–32.
  - `pass_done` pulses at cycle 33.
- **Back-pressure:** continuous `dec_valid` → `dec_ready` low cycles 23–31. Word 23 (bank 2, addr 7) is accepted at cycle 32; next TRACE starts at cycle 33 on bank 2, decoding bank 1.
- **Bank wrap:** continue to word 31 → `mem_wr_bank` returns to 0 with no RAM write during any read of the same bank. The third pass traces bank 0 and decodes bank 2.
- **Reset mid-DECODE:** assert `rst` at cycle 27 → `tbu_enable`=0 at cycle 28, no `pass_done`. The next pass starts only after 16 new words.
- **Integrated with `tbu`:** an all-zero encoded stream yields 8 decoded 0s per pass. A known encoded sequence yields its input bits in reverse, 8 per pass.

Source files
------------

// File: rtl/viterbi_pkg.sv
// Shared types for the Viterbi decoder: survivor bank index, traceback
// controller states and the mod-3 bank rotation helper.
package viterbi_pkg;

   localparam int NUM_BANKS = 3;

   typedef logic [1:0] bank_t;

   typedef enum logic [1:0] {
      IDLE,
      TRACE,
      DECODE,
      WAIT
   } tbu_ctrl_state_e;

   function automatic bank_t bank_inc(input bank_t b);
      return (b == bank_t'(NUM_BANKS - 1)) ? bank_t'(0) : bank_t'(b + bank_t'(1));
   endfunction

endpackage

// File: rtl/tbu_ctrl.sv
// Survivor-memory sequencer: writes ACS decisions into three rotating banks and
// runs one trace + decode sweep over the two older banks per completed block.
module tbu_ctrl
   import viterbi_pkg::*;
#(
   parameter int DEPTH = 8,
   parameter int AW    = $clog2(DEPTH)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          dec_valid,
   output logic          dec_ready,
   output logic          mem_we,
   output bank_t         mem_wr_bank,
   output logic [AW-1:0] mem_wr_addr,
   output logic          mem_rd_en,
   output bank_t         mem_rd_bank,
   output logic [AW-1:0] mem_rd_addr,
   output logic          tbu_enable,
   output logic          tbu_selection,
   output logic          pass_done
);

   tbu_ctrl_state_e state, state_nxt;

   bank_t         wr_bank;
   logic [AW-1:0] wr_addr;
   logic [1:0]    blk_cnt;
   logic [1:0]    blk_cnt_inc;
   bank_t         tr_bank;
   bank_t         dc_bank;
   logic [AW-1:0] rd_addr;

   logic busy;
   logic last_wr;
   logic xfer;
   logic blk_done;
   logic start;

   assign busy        = (state == TRACE) || (state == DECODE);
   assign last_wr     = (wr_addr == AW'(DEPTH - 1));
   // Holding the closing word keeps the bank rotation from landing on a bank still being read.
   assign dec_ready   = !rst && !(last_wr && busy);
   assign xfer        = dec_valid && dec_ready;
   assign blk_done    = xfer && last_wr;
   assign blk_cnt_inc = (blk_cnt == 2'd2) ? 2'd2 : blk_cnt + 2'd1;
   assign start       = blk_done && (blk_cnt_inc == 2'd2);

   assign mem_we      = xfer;
   assign mem_wr_bank = wr_bank;
   assign mem_wr_addr = wr_addr;
   assign mem_rd_en   = busy;
   assign mem_rd_addr = busy ? rd_addr : '0;

   always_comb begin
      mem_rd_bank = '0;
      if (state == TRACE)
         mem_rd_bank = tr_bank;
      else if (state == DECODE)
         mem_rd_bank = dc_bank;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE, WAIT: if (start) state_nxt = TRACE;
         TRACE:      if (rd_addr == '0) state_nxt = DECODE;
         DECODE:     if (rd_addr == '0) state_nxt = WAIT;
         default:    state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst)
         state <= IDLE;
      else
         state <= state_nxt;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_bank       <= '0;
         wr_addr       <= '0;
         blk_cnt       <= '0;
         tr_bank       <= '0;
         dc_bank       <= '0;
         rd_addr       <= '0;
         tbu_enable    <= 1'b0;
         tbu_selection <= 1'b0;
         pass_done     <= 1'b0;
      end else begin
         if (xfer) begin
            wr_addr <= last_wr ? '0 : wr_addr + AW'(1);
            if (last_wr)
               wr_bank <= bank_inc(wr_bank);
         end
         if (blk_done)
            blk_cnt <= blk_cnt_inc;
         if (!busy && start) begin
            tr_bank <= wr_bank;
            dc_bank <= bank_inc(bank_inc(wr_bank));
         end
         // DEPTH is a power of two, so the down-count wraps straight back to DEPTH-1.
         rd_addr       <= busy ? rd_addr - AW'(1) : AW'(DEPTH - 1);
         // One-cycle RAM latency: tbu controls line up with the returning read data.
         tbu_enable    <= busy;
         tbu_selection <= (state == DECODE);
         pass_done     <= tbu_enable && !busy;
      end
   end

endmodule
